// File: rtl/imm_encode.sv
// Scatters a signed immediate into RISC-V I/S/B/J instruction fields behind a two-entry valid/ready buffer.
// Optional macro IMM_STRICT_EN: out-of-range words are consumed and counted but never emitted.
module imm_encode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ImmSrc,
    input  logic [31:0]      Imm,
    input  logic [31:0]      Base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Instr,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    // Handshake: a word moves on a rising edge where valid and ready are both high;
    // valid never waits on ready, and in_ready depends only on buffer occupancy (and reset).
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [31:0]       head_instr_q, head_instr_d;
    logic              head_err_q, head_err_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic              skid_err_q, skid_err_d;
    logic [CNT_W-1:0]  enc_count_q, enc_count_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;

    logic [31:0] enc_instr;
    logic        rerr;
    logic        w_err;
    logic        accept;
    logic        pop;
    logic        push;

    always_comb begin
        enc_instr = Base;
        rerr      = 1'b0;
        case (ImmSrc)
            2'b00: begin
                enc_instr[31:20] = Imm[11:0];
                rerr = ~(&Imm[31:11] | ~|Imm[31:11]);
            end
            2'b01: begin
                enc_instr[31:25] = Imm[11:5];
                enc_instr[11:7]  = Imm[4:0];
                rerr = ~(&Imm[31:11] | ~|Imm[31:11]);
            end
            2'b10: begin
                enc_instr[31]    = Imm[12];
                enc_instr[30:25] = Imm[10:5];
                enc_instr[11:8]  = Imm[4:1];
                enc_instr[7]     = Imm[11];
                rerr = ~(&Imm[31:12] | ~|Imm[31:12]) | Imm[0];
            end
            default: begin
                enc_instr[31]    = Imm[20];
                enc_instr[30:21] = Imm[10:1];
                enc_instr[20]    = Imm[11];
                enc_instr[19:12] = Imm[19:12];
                rerr = ~(&Imm[31:20] | ~|Imm[31:20]) | Imm[0];
            end
        endcase
    end

    assign in_ready  = ~reset & (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef IMM_STRICT_EN
    // Failing words are swallowed here so the buffer only ever holds clean words.
    assign push  = accept & ~rerr;
    assign w_err = 1'b0;
`else
    assign push  = accept;
    assign w_err = rerr;
`endif

    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_err_d   = head_err_q;
        skid_instr_d = skid_instr_q;
        skid_err_d   = skid_err_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_instr_d = enc_instr;
                    head_err_d   = w_err;
                    state_d      = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_instr_d = enc_instr;
                    head_err_d   = w_err;
                end else if (push) begin
                    skid_instr_d = enc_instr;
                    skid_err_d   = w_err;
                    state_d      = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_instr_d = skid_instr_q;
                    head_err_d   = skid_err_q;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (push && (enc_count_q != {CNT_W{1'b1}}))
            enc_count_d = enc_count_q + CNT_ONE;
        if (accept && rerr && (err_count_q != {CNT_W{1'b1}}))
            err_count_d = err_count_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            head_instr_q <= '0;
            head_err_q   <= 1'b0;
            skid_instr_q <= '0;
            skid_err_q   <= 1'b0;
            enc_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_err_q   <= head_err_d;
            skid_instr_q <= skid_instr_d;
            skid_err_q   <= skid_err_d;
            enc_count_q  <= enc_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign Instr     = head_instr_q;
    assign out_err   = head_err_q;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encode.sv
// Directed and random checks for imm_encode using an expected-word queue and narrow counters.
module tb_imm_encode;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    ImmSrc = 2'b00;
    logic [31:0]   Imm = '0;
    logic [31:0]   Base = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   Instr;
    logic          out_err;
    logic [CW-1:0] enc_count;
    logic [CW-1:0] err_count;

    int total = 0;
    int bad   = 0;
    int exp_enc = 0;
    int exp_err = 0;
    logic [32:0] exp_q[$];

    imm_encode #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ImmSrc(ImmSrc), .Imm(Imm), .Base(Base), .out_valid(out_valid),
        .out_ready(out_ready), .Instr(Instr), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder written with masks and shifts, range test by signed compare.
    function automatic void model(input logic [1:0] src, input logic [31:0] imm,
                                  input logic [31:0] base, output logic [31:0] ins,
                                  output logic err);
        int s;
        s = $signed(imm);
        case (src)
            2'd0: begin
                ins = (base & 32'h000F_FFFF) | ((imm & 32'hFFF) << 20);
                err = (s < -2048) || (s > 2047);
            end
            2'd1: begin
                ins = (base & 32'h01FF_F07F) | ((imm & 32'hFE0) << 20) | ((imm & 32'h1F) << 7);
                err = (s < -2048) || (s > 2047);
            end
            2'd2: begin
                ins = (base & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) |
                      (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
                      (((imm >> 11) & 32'h1) << 7);
                err = (s < -4096) || (s > 4095) || imm[0];
            end
            default: begin
                ins = (base & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31) |
                      (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
                      (((imm >> 12) & 32'hFF) << 12);
                err = (s < -(1 << 20)) || (s > (1 << 20) - 1) || imm[0];
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {31'b0, out_valid}, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("sb_instr", {32'b0, Instr}, {32'b0, e[31:0]});
                check("sb_out_err", {63'b0, out_err}, {63'b0, e[32]});
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        #1 check("in_ready_in_reset", {63'b0, in_ready}, 64'd0);
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        exp_enc = 0;
        exp_err = 0;
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
        @(posedge clk); #1;
        in_valid = 1'b1;
        ImmSrc = src;
        Imm = imm;
        Base = base;
    endtask

    // Waits for the driven word to be taken; frees the output if it stalls for a cycle.
    task automatic wait_accept();
        logic [31:0] ei;
        logic ee;
        bit ok;
        ok = 0;
        model(ImmSrc, Imm, Base, ei, ee);
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
`ifdef IMM_STRICT_EN
                if (!ee) begin
                    exp_q.push_back({1'b0, ei});
                    if (exp_enc != MAXC) exp_enc++;
                end
`else
                exp_q.push_back({ee, ei});
                if (exp_enc != MAXC) exp_enc++;
`endif
                if (ee && exp_err != MAXC) exp_err++;
            end
            @(posedge clk); #1;
            if (!ok) out_ready = 1'b1;
        end
        in_valid = 1'b0;
        check("accept_timeout", {63'b0, ok}, 64'd1);
    endtask

    task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
        drive(src, imm, base);
        wait_accept();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
        #1 check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_counts();
        check("enc_count", {60'b0, enc_count}, 64'(exp_enc));
        check("err_count", {60'b0, err_count}, 64'(exp_err));
    endtask

    initial begin
        do_reset(2);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_instr", {32'b0, Instr}, 64'd0);
        check("rst_out_err", {63'b0, out_err}, 64'd0);
        check_counts();

        // I-type, held at the output to see the one-cycle latency.
        out_ready = 1'b0;
        send(2'b00, 32'h0000_0005, 32'h0000_0013);
        check("i_valid", {63'b0, out_valid}, 64'd1);
        check("i_instr", {32'b0, Instr}, 64'h0050_0013);
        check("i_err", {63'b0, out_err}, 64'd0);
        check("i_enc", {60'b0, enc_count}, 64'd1);
        drain();

        send(2'b01, 32'hFFFF_FFFC, 32'h0000_2023);
        check("s_instr", {32'b0, Instr}, 64'hFE00_2E23);
        send(2'b10, 32'h0000_0008, 32'h0000_0063);
        check("b_instr", {32'b0, Instr}, 64'h0000_0463);
        send(2'b11, 32'hFFFF_FFFE, 32'h0000_00EF);
        check("j_instr", {32'b0, Instr}, 64'hFFFF_F0EF);
        drain();
        check_counts();

        // Range error on a fresh block.
        do_reset(1);
        out_ready = 1'b0;
        send(2'b00, 32'h0000_0800, 32'h0000_0013);
`ifdef IMM_STRICT_EN
        check("rerr_valid", {63'b0, out_valid}, 64'd0);
        check("rerr_enc", {60'b0, enc_count}, 64'd0);
`else
        check("rerr_valid", {63'b0, out_valid}, 64'd1);
        check("rerr_instr", {32'b0, Instr}, 64'h8000_0013);
        check("rerr_flag", {63'b0, out_err}, 64'd1);
        check("rerr_enc", {60'b0, enc_count}, 64'd1);
`endif
        check("rerr_errcnt", {60'b0, err_count}, 64'd1);
        drain();
        send(2'b10, 32'h0000_0011, 32'h0000_0063);
        send(2'b11, 32'h0010_0000, 32'h0000_006F);
        send(2'b10, 32'hFFFF_F000, 32'h0000_0063);
        drain();
        check_counts();

        // Backpressure: A and B fill the buffer, C waits.
        do_reset(1);
        out_ready = 1'b0;
        send(2'b00, 32'h0000_0001, 32'h0000_0093);
        send(2'b00, 32'h0000_0002, 32'h0000_0113);
        drive(2'b00, 32'h0000_0003, 32'h0000_0193);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("full_in_ready", {63'b0, in_ready}, 64'd0);
            check("full_head", {32'b0, Instr}, 64'h0010_0093);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_accept();
        drain();
        check("bp_enc", {60'b0, enc_count}, 64'd3);

        // Reset while FULL discards buffered words.
        out_ready = 1'b0;
        send(2'b01, 32'h0000_0010, 32'h0000_2023);
        send(2'b01, 32'h0000_0020, 32'h0000_2023);
        check("mid_full", {63'b0, in_ready}, 64'd0);
        do_reset(1);
        check("mid_valid", {63'b0, out_valid}, 64'd0);
        check("mid_instr", {32'b0, Instr}, 64'd0);
        check_counts();
        send(2'b00, 32'hFFFF_FFFF, 32'h0000_0013);
        check("post_valid", {63'b0, out_valid}, 64'd1);
        check("post_instr", {32'b0, Instr}, 64'hFFF0_0013);
        drain();

        // Random mix with random backpressure; narrow counters saturate here.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] r_imm;
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                r_imm = $urandom;
            else
                r_imm = 32'($signed(13'($urandom_range(0, 8191))));
            send(2'($urandom_range(0, 3)), r_imm, $urandom);
        end
        drain();
        check_counts();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
